// File: rtl/io_bus_scheduler_if.sv
// Shared emulator I/O bus bundle: three requester handshakes, display ready, strobes and bus data.
// The scheduler takes the slave modport; the requesters/environment take the master modport.
interface io_bus_scheduler_if;
  logic       in12_req;
  logic [3:0] in12_anode;
  logic [7:0] in12_cathode;
  logic       in12_done;
  logic       kb_req;
  logic [7:0] kb_col;
  logic [6:0] kb_row_in;
  logic [6:0] kb_row;
  logic       kb_done;
  logic       ms_req;
  logic [7:0] ms_addr;
  logic [7:0] ms_data;
  logic       ms6205_ready;
  logic       ms_done;
  logic       ms_timeout;
  logic [7:0] bus_data;
  logic       in12_clear_n;
  logic       in12_write_anode;
  logic       in12_write_cathode;
  logic       keyboard_clear;
  logic       keyboard_write;
  logic       keyboard_read;
  logic       ms6205_write_addr_n;
  logic       ms6205_write_data_n;
  logic       busy;

  modport slave (
    input  in12_req, in12_anode, in12_cathode, kb_req, kb_col, kb_row_in,
           ms_req, ms_addr, ms_data, ms6205_ready,
    output in12_done, kb_row, kb_done, ms_done, ms_timeout, bus_data,
           in12_clear_n, in12_write_anode, in12_write_cathode,
           keyboard_clear, keyboard_write, keyboard_read,
           ms6205_write_addr_n, ms6205_write_data_n, busy
  );

  modport master (
    output in12_req, in12_anode, in12_cathode, kb_req, kb_col, kb_row_in,
           ms_req, ms_addr, ms_data, ms6205_ready,
    input  in12_done, kb_row, kb_done, ms_done, ms_timeout, bus_data,
           in12_clear_n, in12_write_anode, in12_write_cathode,
           keyboard_clear, keyboard_write, keyboard_read,
           ms6205_write_addr_n, ms6205_write_data_n, busy
  );
endinterface

// File: rtl/io_bus_scheduler.sv
// Round-robin scheduler for the shared emulator I/O bus: IN-12 refresh, keyboard scan, MS6205 write.
// Define IO_BUS_WATCHDOG_EN to abort an MS6205 transaction when ready never arrives.
module io_bus_scheduler #(
  parameter int unsigned SETUP_US         = 1,
  parameter int unsigned STROBE_US        = 2,
  parameter int unsigned READY_TIMEOUT_US = 255
) (
  input  logic              Clock_1us,
  input  logic              Rst,
  io_bus_scheduler_if.slave bus
);
  localparam int unsigned CntW = $clog2(SETUP_US + STROBE_US + 2);
  localparam logic [CntW-1:0] StbFirst = CntW'(SETUP_US);
  localparam logic [CntW-1:0] StbLast  = CntW'(SETUP_US + STROBE_US - 1);
  localparam logic [CntW-1:0] HoldCnt  = CntW'(SETUP_US + STROBE_US);
  localparam logic [1:0] ReqIn12 = 2'd0;
  localparam logic [1:0] ReqKb   = 2'd1;
  localparam logic [1:0] ReqMs   = 2'd2;

  if (SETUP_US < 1 || STROBE_US < 1 || READY_TIMEOUT_US < 1 || READY_TIMEOUT_US > 255)
  begin : g_bad_param
    $error("io_bus_scheduler: timing parameter out of range");
  end

  typedef enum logic [1:0] {StIdle, StWait, StPhase} state_e;

  state_e          state_q, state_d;
  logic [1:0]      who_q, who_d, phase_q, phase_d, rr_q, rr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [7:0]      op1_q, op1_d, op2_q, op2_d, bus_data_q, bus_data_d;
  // strb: in12 clr/anode/cath, kb clr/wr/rd, ms addr/data (all active-high internally)
  logic [7:0]      strb_q, strb_d;
  logic [6:0]      kb_row_q, kb_row_d;
  logic            in12_done_q, in12_done_d, kb_done_q, kb_done_d, ms_done_q, ms_done_d;
  logic            busy_q, busy_d;
  logic [3:0]      reqs;
  logic [1:0]      cand, gnt;
  logic            gnt_vld;
`ifdef IO_BUS_WATCHDOG_EN
  logic [7:0]      wd_q, wd_d;
  logic            timeout_q, timeout_d;
`endif

  function automatic logic [1:0] rr_next(input logic [1:0] r);
    return (r == ReqMs) ? ReqIn12 : r + 2'd1;
  endfunction

  // rr_q holds the requester with highest priority for the next grant
  always_comb begin
    reqs    = {1'b0, bus.ms_req, bus.kb_req, bus.in12_req};
    gnt_vld = 1'b0;
    gnt     = rr_q;
    cand    = rr_q;
    for (int k = 0; k < 3; k++) begin
      if (!gnt_vld && reqs[cand]) begin
        gnt_vld = 1'b1;
        gnt     = cand;
      end
      cand = rr_next(cand);
    end
  end

  always_comb begin
    state_d     = state_q;
    who_d       = who_q;
    phase_d     = phase_q;
    rr_d        = rr_q;
    cnt_d       = cnt_q;
    op1_d       = op1_q;
    op2_d       = op2_q;
    kb_row_d    = kb_row_q;
    in12_done_d = 1'b0;
    kb_done_d   = 1'b0;
    ms_done_d   = 1'b0;
`ifdef IO_BUS_WATCHDOG_EN
    wd_d        = wd_q;
    timeout_d   = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        if (gnt_vld) begin
          who_d = gnt;
          rr_d  = rr_next(gnt);
          cnt_d = '0;
          unique case (gnt)
            ReqIn12: begin op1_d = {4'h0, bus.in12_anode}; op2_d = bus.in12_cathode; end
            ReqKb:   begin op1_d = bus.kb_col;             op2_d = 8'h09;            end
            default: begin op1_d = bus.ms_addr;            op2_d = bus.ms_data;      end
          endcase
          if (gnt == ReqMs) begin
            state_d = StWait;
`ifdef IO_BUS_WATCHDOG_EN
            wd_d    = 8'd0;
`endif
          end else begin
            state_d = StPhase;
            phase_d = 2'd0;
          end
        end
      end
      StWait: begin
        if (bus.ms6205_ready) begin
          state_d = StPhase;
          phase_d = 2'd1;
          cnt_d   = '0;
        end
`ifdef IO_BUS_WATCHDOG_EN
        else if (wd_q == 8'(READY_TIMEOUT_US - 1)) begin
          state_d   = StIdle;
          ms_done_d = 1'b1;
          timeout_d = 1'b1;
        end else begin
          wd_d = wd_q + 8'd1;
        end
`endif
      end
      StPhase: begin
        if (who_q == ReqKb && phase_q == 2'd2 && cnt_q == StbLast) kb_row_d = bus.kb_row_in;
        if (cnt_q == HoldCnt) begin
          cnt_d = '0;
          if (phase_q == 2'd2) begin
            state_d     = StIdle;
            in12_done_d = (who_q == ReqIn12);
            kb_done_d   = (who_q == ReqKb);
            ms_done_d   = (who_q == ReqMs);
          end else begin
            phase_d = phase_q + 2'd1;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    // Outputs are decoded from the next state so they come straight off flops
    bus_data_d = 8'h00;
    strb_d     = 8'h00;
    if (state_d == StPhase) begin
      bus_data_d = (phase_d == 2'd0) ? 8'h00 : ((phase_d == 2'd1) ? op1_d : op2_d);
      if (cnt_d >= StbFirst && cnt_d <= StbLast) begin
        case ({who_d, phase_d})
          4'b0000: strb_d[0] = 1'b1;
          4'b0001: strb_d[1] = 1'b1;
          4'b0010: strb_d[2] = 1'b1;
          4'b0100: strb_d[3] = 1'b1;
          4'b0101: strb_d[4] = 1'b1;
          4'b0110: strb_d[5] = 1'b1;
          4'b1001: strb_d[6] = 1'b1;
          4'b1010: strb_d[7] = 1'b1;
          default: ;
        endcase
      end
    end
    busy_d = (state_d != StIdle) | in12_done_d | kb_done_d | ms_done_d;
  end

  always_ff @(posedge Clock_1us or posedge Rst) begin
    if (Rst) begin
      state_q     <= StIdle;
      who_q       <= ReqIn12;
      phase_q     <= 2'd0;
      rr_q        <= ReqIn12;
      cnt_q       <= '0;
      op1_q       <= 8'h00;
      op2_q       <= 8'h00;
      bus_data_q  <= 8'h00;
      strb_q      <= 8'h00;
      kb_row_q    <= 7'h00;
      in12_done_q <= 1'b0;
      kb_done_q   <= 1'b0;
      ms_done_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      who_q       <= who_d;
      phase_q     <= phase_d;
      rr_q        <= rr_d;
      cnt_q       <= cnt_d;
      op1_q       <= op1_d;
      op2_q       <= op2_d;
      bus_data_q  <= bus_data_d;
      strb_q      <= strb_d;
      kb_row_q    <= kb_row_d;
      in12_done_q <= in12_done_d;
      kb_done_q   <= kb_done_d;
      ms_done_q   <= ms_done_d;
      busy_q      <= busy_d;
    end
  end

`ifdef IO_BUS_WATCHDOG_EN
  always_ff @(posedge Clock_1us or posedge Rst) begin
    if (Rst) begin
      wd_q      <= 8'd0;
      timeout_q <= 1'b0;
    end else begin
      wd_q      <= wd_d;
      timeout_q <= timeout_d;
    end
  end
  assign bus.ms_timeout = timeout_q;
`else
  assign bus.ms_timeout = 1'b0;
`endif

  assign bus.bus_data            = bus_data_q;
  assign bus.in12_clear_n        = ~strb_q[0];
  assign bus.in12_write_anode    = strb_q[1];
  assign bus.in12_write_cathode  = strb_q[2];
  assign bus.keyboard_clear      = strb_q[3];
  assign bus.keyboard_write      = strb_q[4];
  assign bus.keyboard_read       = strb_q[5];
  assign bus.ms6205_write_addr_n = ~strb_q[6];
  assign bus.ms6205_write_data_n = ~strb_q[7];
  assign bus.kb_row              = kb_row_q;
  assign bus.in12_done           = in12_done_q;
  assign bus.kb_done             = kb_done_q;
  assign bus.ms_done             = ms_done_q;
  assign bus.busy                = busy_q;
endmodule

// File: tb/tb_io_bus_scheduler.sv
// Bench for io_bus_scheduler: transaction-level model compared every cycle, plus literal
// expectations pinned to grant-relative cycle numbers.
module tb_io_bus_scheduler;
  localparam int SETUP  = 1;
  localparam int STROBE = 2;
  localparam int L      = SETUP + STROBE + 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  int   g;

  io_bus_scheduler_if bus_if ();

  io_bus_scheduler #(
    .SETUP_US        (SETUP),
    .STROBE_US       (STROBE),
    .READY_TIMEOUT_US(255)
  ) dut (
    .Clock_1us(clk),
    .Rst      (rst),
    .bus      (bus_if.slave)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Model: one transaction record; m_t is cycles since grant on a 3-phase timeline
  bit         m_act = 0, m_wait = 0, m_to = 0;
  bit         m_done [3] = '{0, 0, 0};
  int         m_who = 0, m_t = 0, m_wcnt = 0, m_rr = 0;
  logic [7:0] m_op1 = 8'h00, m_op2 = 8'h00;
  logic [6:0] m_row = 7'h00;

  function automatic bit req_of(input int i);
    case (i)
      0:       return bus_if.in12_req;
      1:       return bus_if.kb_req;
      default: return bus_if.ms_req;
    endcase
  endfunction

  task automatic model_step();
    if (rst) begin
      m_act = 0; m_wait = 0; m_to = 0; m_who = 0; m_t = 0; m_wcnt = 0; m_rr = 0;
      m_done = '{0, 0, 0};
      m_row = 7'h00;
      return;
    end
    m_done = '{0, 0, 0};
    m_to   = 0;
    if (m_act) begin
      if (m_wait) begin
        if (bus_if.ms6205_ready) begin
          m_wait = 0;
          m_t    = L;
        end else begin
          m_wcnt++;
`ifdef IO_BUS_WATCHDOG_EN
          if (m_wcnt == 255) begin
            m_act = 0; m_wait = 0; m_done[2] = 1; m_to = 1;
          end
`endif
        end
      end else begin
        if (m_who == 1 && m_t == 3 * L - 2) m_row = bus_if.kb_row_in;
        if (m_t == 3 * L - 1) begin
          m_act = 0;
          m_done[m_who] = 1;
        end else begin
          m_t++;
        end
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        int idx = (m_rr + k) % 3;
        if (!m_act && req_of(idx)) begin
          m_act = 1; m_who = idx; m_t = 0; m_wcnt = 0;
          m_wait = (idx == 2);
          m_rr = (idx + 1) % 3;
          case (idx)
            0:       begin m_op1 = {4'h0, bus_if.in12_anode}; m_op2 = bus_if.in12_cathode; end
            1:       begin m_op1 = bus_if.kb_col;            m_op2 = 8'h09;              end
            default: begin m_op1 = bus_if.ms_addr;           m_op2 = bus_if.ms_data;     end
          endcase
        end
      end
    end
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    model_step();
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic compare();
    bit         on, stb;
    int         p, s, n_stb;
    logic [7:0] eb;
    on  = m_act && !m_wait;
    p   = m_t / L;
    s   = m_t % L;
    stb = on && s >= SETUP && s < SETUP + STROBE;
    eb  = !on ? 8'h00 : ((p == 0) ? 8'h00 : ((p == 1) ? m_op1 : m_op2));
    chk("bus_data", 32'(bus_if.bus_data), 32'(eb));
    chk("in12_clear_n", 32'(bus_if.in12_clear_n), 32'(!(stb && m_who == 0 && p == 0)));
    chk("in12_write_anode", 32'(bus_if.in12_write_anode), 32'(stb && m_who == 0 && p == 1));
    chk("in12_write_cathode", 32'(bus_if.in12_write_cathode), 32'(stb && m_who == 0 && p == 2));
    chk("keyboard_clear", 32'(bus_if.keyboard_clear), 32'(stb && m_who == 1 && p == 0));
    chk("keyboard_write", 32'(bus_if.keyboard_write), 32'(stb && m_who == 1 && p == 1));
    chk("keyboard_read", 32'(bus_if.keyboard_read), 32'(stb && m_who == 1 && p == 2));
    chk("ms_addr_n", 32'(bus_if.ms6205_write_addr_n), 32'(!(stb && m_who == 2 && p == 1)));
    chk("ms_data_n", 32'(bus_if.ms6205_write_data_n), 32'(!(stb && m_who == 2 && p == 2)));
    chk("in12_done", 32'(bus_if.in12_done), 32'(m_done[0]));
    chk("kb_done", 32'(bus_if.kb_done), 32'(m_done[1]));
    chk("ms_done", 32'(bus_if.ms_done), 32'(m_done[2]));
    chk("ms_timeout", 32'(bus_if.ms_timeout), 32'(m_to));
    chk("kb_row", 32'(bus_if.kb_row), 32'(m_row));
    chk("busy", 32'(bus_if.busy), 32'(m_act || m_done[0] || m_done[1] || m_done[2]));
    n_stb = int'(!bus_if.in12_clear_n) + int'(bus_if.in12_write_anode)
          + int'(bus_if.in12_write_cathode) + int'(bus_if.keyboard_clear)
          + int'(bus_if.keyboard_write) + int'(bus_if.keyboard_read)
          + int'(!bus_if.ms6205_write_addr_n) + int'(!bus_if.ms6205_write_data_n);
    chk("one_strobe", 32'(n_stb <= 1), 32'd1);
  endtask

  initial forever begin
    @(negedge clk);
    compare();
  end

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  initial begin
    bus_if.in12_req = 0; bus_if.in12_anode = 4'h0; bus_if.in12_cathode = 8'h00;
    bus_if.kb_req = 0; bus_if.kb_col = 8'h00; bus_if.kb_row_in = 7'h00;
    bus_if.ms_req = 0; bus_if.ms_addr = 8'h00; bus_if.ms_data = 8'h00;
    bus_if.ms6205_ready = 0;
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_bus", 32'(bus_if.bus_data), 32'h0);
    chk("rst_clear_n", 32'(bus_if.in12_clear_n), 32'h1);
    chk("rst_addr_n", 32'(bus_if.ms6205_write_addr_n), 32'h1);
    chk("rst_busy", 32'(bus_if.busy), 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // IN-12 refresh, operands changed after grant
    bus_if.in12_anode = 4'h5; bus_if.in12_cathode = 8'h3A; bus_if.in12_req = 1; g = cyc + 1;
    wait_until(g);
    bus_if.in12_req = 0; bus_if.in12_anode = 4'hF; bus_if.in12_cathode = 8'h00;
    chk("t1_setup_busy", 32'(bus_if.busy), 32'h1);
    chk("t1_setup_clr", 32'(bus_if.in12_clear_n), 32'h1);
    wait_until(g + 1); chk("t1_clr_lo", 32'(bus_if.in12_clear_n), 32'h0);
    wait_until(g + 3); chk("t1_clr_hold", 32'(bus_if.in12_clear_n), 32'h1);
    wait_until(g + 5);
    chk("t1_an_bus", 32'(bus_if.bus_data), 32'h05);
    chk("t1_an_stb", 32'(bus_if.in12_write_anode), 32'h1);
    wait_until(g + 9);
    chk("t1_ca_bus", 32'(bus_if.bus_data), 32'h3A);
    chk("t1_ca_stb", 32'(bus_if.in12_write_cathode), 32'h1);
    wait_until(g + 11); chk("t1_done_early", 32'(bus_if.in12_done), 32'h0);
    wait_until(g + 12); chk("t1_done", 32'(bus_if.in12_done), 32'h1);
    wait_until(g + 13); chk("t1_idle", 32'(bus_if.busy), 32'h0);

    // Keyboard scan; row lines valid only around the sampling cycle
    bus_if.kb_col = 8'h04; bus_if.kb_row_in = 7'h7F; bus_if.kb_req = 1; g = cyc + 1;
    wait_until(g); bus_if.kb_req = 0; bus_if.kb_col = 8'hFF;
    wait_until(g + 1); chk("t2_clr", 32'(bus_if.keyboard_clear), 32'h1);
    wait_until(g + 5);
    chk("t2_wr", 32'(bus_if.keyboard_write), 32'h1);
    chk("t2_wr_bus", 32'(bus_if.bus_data), 32'h04);
    wait_until(g + 9);
    chk("t2_rd", 32'(bus_if.keyboard_read), 32'h1);
    chk("t2_rd_bus", 32'(bus_if.bus_data), 32'h09);
    wait_until(g + 10); bus_if.kb_row_in = 7'h12;
    wait_until(g + 11); bus_if.kb_row_in = 7'h55;
    wait_until(g + 12);
    chk("t2_done", 32'(bus_if.kb_done), 32'h1);
    chk("t2_row", 32'(bus_if.kb_row), 32'h12);
    wait_until(g + 14);

    // All three requesting from a fresh pointer
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    bus_if.in12_anode = 4'h2; bus_if.in12_cathode = 8'h81; bus_if.kb_col = 8'h10;
    bus_if.ms_addr = 8'h20; bus_if.ms_data = 8'h41; bus_if.ms6205_ready = 1;
    bus_if.in12_req = 1; bus_if.kb_req = 1; bus_if.ms_req = 1; g = cyc + 1;
    wait_until(g + 1);
    chk("t3_in12_first", 32'(bus_if.in12_clear_n), 32'h0);
    chk("t3_kb_not_yet", 32'(bus_if.keyboard_clear), 32'h0);
    wait_until(g + 12); chk("t3_in12_done", 32'(bus_if.in12_done), 32'h1);
    wait_until(g + 14); chk("t3_kb_second", 32'(bus_if.keyboard_clear), 32'h1);
    wait_until(g + 25); chk("t3_kb_done", 32'(bus_if.kb_done), 32'h1);
    wait_until(g + 28);
    chk("t3_ms_addr", 32'(bus_if.ms6205_write_addr_n), 32'h0);
    chk("t3_ms_bus", 32'(bus_if.bus_data), 32'h20);
    wait_until(g + 35); chk("t3_ms_done", 32'(bus_if.ms_done), 32'h1);
    wait_until(g + 37); chk("t3_in12_again", 32'(bus_if.in12_clear_n), 32'h0);
    wait_until(g + 40); bus_if.in12_req = 0; bus_if.kb_req = 0; bus_if.ms_req = 0;
    wait_until(g + 52); chk("t3_drained", 32'(bus_if.busy), 32'h0);

    // MS6205 waiting 40 cycles on ready; ready then drops mid-transaction
    bus_if.ms6205_ready = 0; bus_if.ms_addr = 8'h7E; bus_if.ms_data = 8'hC3;
    bus_if.ms_req = 1; g = cyc + 1;
    wait_until(g); bus_if.ms_req = 0;
    wait_until(g + 40);
    chk("t4_wait_bus", 32'(bus_if.bus_data), 32'h00);
    chk("t4_wait_busy", 32'(bus_if.busy), 32'h1);
    bus_if.ms6205_ready = 1;
    wait_until(g + 41);
    chk("t4_addr_setup", 32'(bus_if.bus_data), 32'h7E);
    chk("t4_addr_setup_n", 32'(bus_if.ms6205_write_addr_n), 32'h1);
    wait_until(g + 42);
    chk("t4_addr_stb", 32'(bus_if.ms6205_write_addr_n), 32'h0);
    bus_if.ms6205_ready = 0;
    wait_until(g + 46);
    chk("t4_data_stb", 32'(bus_if.ms6205_write_data_n), 32'h0);
    chk("t4_data_bus", 32'(bus_if.bus_data), 32'hC3);
    wait_until(g + 49); chk("t4_done", 32'(bus_if.ms_done), 32'h1);
    wait_until(g + 51);

    // Ready stuck low
    bus_if.ms6205_ready = 0; bus_if.ms_req = 1; g = cyc + 1;
    wait_until(g); bus_if.ms_req = 0;
`ifdef IO_BUS_WATCHDOG_EN
    wait_until(g + 254); chk("t5_not_yet", 32'(bus_if.ms_done), 32'h0);
    wait_until(g + 255);
    chk("t5_wd_done", 32'(bus_if.ms_done), 32'h1);
    chk("t5_wd_timeout", 32'(bus_if.ms_timeout), 32'h1);
    wait_until(g + 257); chk("t5_idle", 32'(bus_if.busy), 32'h0);
`else
    wait_until(g + 300);
    chk("t5_still_busy", 32'(bus_if.busy), 32'h1);
    chk("t5_no_done", 32'(bus_if.ms_done), 32'h0);
    bus_if.ms6205_ready = 1;
    wait_until(g + 309); chk("t5_late_done", 32'(bus_if.ms_done), 32'h1);
    bus_if.ms6205_ready = 0;
    wait_until(g + 312);
`endif

    // Asynchronous reset during the anode strobe
    bus_if.in12_anode = 4'h9; bus_if.in12_cathode = 8'h66; bus_if.in12_req = 1; g = cyc + 1;
    wait_until(g + 5);
    chk("t6_anode_on", 32'(bus_if.in12_write_anode), 32'h1);
    bus_if.in12_req = 0;
    #1 rst = 1'b1;
    #1;
    chk("t6_anode_off", 32'(bus_if.in12_write_anode), 32'h0);
    chk("t6_bus", 32'(bus_if.bus_data), 32'h00);
    chk("t6_busy", 32'(bus_if.busy), 32'h0);
    chk("t6_clear_n", 32'(bus_if.in12_clear_n), 32'h1);
    @(posedge clk); @(posedge clk); @(negedge clk);
    rst = 1'b0;
    g = cyc;
    wait_until(g + 20);
    chk("t6_no_done", 32'(bus_if.in12_done), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
